// File: rtl/class_seq_pkg.sv
// class_seq_pkg: shared state encoding and default counter width for class_seq
package class_seq_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        TRAIN,
        INFER,
        PRED1,
        PRED2,
        OUT
    } state_t;

endpackage

// File: rtl/class_seq_ctrl.sv
// class_seq_ctrl: session FSM, training counter and deferred stop for class_seq
module class_seq_ctrl
    import class_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_train,
    input  logic             s_valid,
    input  logic             m_ready,
    output logic             s_ready,
    output logic             beat,
    output logic             train_beat,
    output logic             res_en,
    output logic             start_acc,
    output logic             cls_op,
    output logic             m_valid,
    output logic             busy,
    output logic             train_done
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             stop_l;

    // stop in INFER wins over a simultaneous beat
    assign s_ready    = state == TRAIN || (state == INFER && !stop && !stop_l);
    assign beat       = s_valid && s_ready;
    assign train_beat = beat && state == TRAIN;
    assign res_en     = state == PRED2;
    assign start_acc  = start && state == IDLE;
    assign m_valid    = state == OUT;
    assign busy       = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            stop_l     <= 1'b0;
            cls_op     <= 1'b1;
            train_done <= 1'b0;
        end else begin
            cls_op <= !train_beat;
            if (state inside {TRAIN, PRED1, PRED2, OUT})
                stop_l <= stop_l | stop;
            case (state)
                IDLE: if (start) begin
                    cnt        <= num_train;
                    stop_l     <= 1'b0;
                    train_done <= num_train == '0;
                    state      <= num_train == '0 ? INFER : TRAIN;
                end
                TRAIN: if (s_valid) begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state      <= INFER;
                        train_done <= 1'b1;
                    end
                end
                INFER: if (stop || stop_l) begin
                    state  <= IDLE;
                    stop_l <= 1'b0;
                end else if (s_valid) begin
                    state <= PRED1;
                end
                PRED1:   state <= PRED2;
                PRED2:   state <= OUT;
                OUT:     if (m_ready) state <= INFER;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/class_seq.sv
// class_seq: HDC classifier sequencer (train then infer); CLASS_SEQ_STATS_EN adds n_infer/n_seizure counters
module class_seq
    import class_seq_pkg::*;
#(
    parameter int DIMENSIONS = 10000,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_W-1:0]      num_train,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DIMENSIONS-1:0] s_hv,
    input  logic                  s_label,
    output logic                  cls_op,
    output logic                  cls_label,
    output logic [DIMENSIONS-1:0] cls_hv,
    input  logic                  cls_pred,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_label,
    output logic                  busy,
    output logic                  train_done
`ifdef CLASS_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0]      n_infer,
    output logic [CNT_W-1:0]      n_seizure
`endif
);

    logic beat, train_beat, res_en, start_acc;

    class_seq_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .num_train  (num_train),
        .s_valid    (s_valid),
        .m_ready    (m_ready),
        .s_ready    (s_ready),
        .beat       (beat),
        .train_beat (train_beat),
        .res_en     (res_en),
        .start_acc  (start_acc),
        .cls_op     (cls_op),
        .m_valid    (m_valid),
        .busy       (busy),
        .train_done (train_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_hv    <= '0;
            cls_label <= 1'b0;
            m_label   <= 1'b0;
        end else begin
            if (beat)
                cls_hv <= s_hv;
            if (train_beat)
                cls_label <= s_label;
            if (res_en)
                m_label <= cls_pred;
        end
    end

`ifdef CLASS_SEQ_STATS_EN
    logic hs;
    assign hs = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_infer   <= '0;
            n_seizure <= '0;
        end else if (start_acc) begin
            n_infer   <= '0;
            n_seizure <= '0;
        end else if (hs) begin
            n_infer   <= &n_infer ? n_infer : n_infer + 1'b1;
            n_seizure <= (m_label && !(&n_seizure)) ? n_seizure + 1'b1 : n_seizure;
        end
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_class_seq.sv
// tb_class_seq: scoreboard bench for class_seq; CLASS_SEQ_STATS_EN also checks saturating counters at CNT_W=2
module tb_class_seq;

    localparam int D = 64;
`ifdef CLASS_SEQ_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif
    localparam int NT_RST = CW > 2 ? 4 : 3;
    localparam int SAT    = (1 << CW) - 1;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic          s_valid = 1'b0, s_label = 1'b0, cls_pred = 1'b0, m_ready = 1'b0;
    logic [CW-1:0] num_train = '0;
    logic [D-1:0]  s_hv = '0;
    logic          s_ready, cls_op, cls_label, m_valid, m_label, busy, train_done;
    logic [D-1:0]  cls_hv;
`ifdef CLASS_SEQ_STATS_EN
    logic [CW-1:0] n_infer, n_seizure;
`endif

    int checks = 0, failures = 0, lows = 0, pulses = 0, hs_cnt = 0;
    logic         prev_op = 1'b1;
    logic         tq_lbl[$];
    logic [D-1:0] tq_hv[$];
    logic         rq[$];

    class_seq #(.DIMENSIONS(D), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .num_train  (num_train),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_hv       (s_hv),
        .s_label    (s_label),
        .cls_op     (cls_op),
        .cls_label  (cls_label),
        .cls_hv     (cls_hv),
        .cls_pred   (cls_pred),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_label    (m_label),
        .busy       (busy),
        .train_done (train_done)
`ifdef CLASS_SEQ_STATS_EN
        ,
        .n_infer    (n_infer),
        .n_seizure  (n_seizure)
`endif
    );

    always #5 clk = ~clk;

    // classifier model: registered prediction is bit 0 of the presented hypervector
    always @(posedge clk) cls_pred <= cls_hv[0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            tq_lbl.delete();
            tq_hv.delete();
        end else begin
            if (!cls_op) begin
                lows++;
                if (prev_op) pulses++;
                if (tq_lbl.size() == 0) check("op_spurious", cls_op, 1);
                else begin
                    check("cls_label", cls_label, tq_lbl.pop_front());
                    check("cls_hv", cls_hv, tq_hv.pop_front());
                end
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                if (rq.size() == 0) check("res_spurious", m_valid, 0);
                else check("m_label", m_label, rq.pop_front());
            end
        end
        prev_op = cls_op;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input int nt);
        num_train = CW'(nt);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic beat(input logic [D-1:0] hv, input logic lbl, input logic tr);
        int n = 0;
        s_valid = 1'b1;
        s_hv = hv;
        s_label = lbl;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s_ready", s_ready, 1);
        if (tr) begin
            tq_lbl.push_back(lbl);
            tq_hv.push_back(hv);
        end else rq.push_back(hv[0]);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mv();
        int n = 0;
        @(negedge clk);
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mv_timeout", m_valid, 1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [D-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int bl, bp, bh, n;
        @(negedge clk);
        check("rst_cls_op", cls_op, 1);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_train_done", train_done, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_label", m_label, 0);
        check("rst_cls_label", cls_label, 0);
        check("rst_cls_hv", cls_hv, 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        go(3);
        bl = lows;
        bp = pulses;
        beat(rnd(), 1'b0, 1'b1);
        beat(rnd(), 1'b1, 1'b1);
        beat(rnd(), 1'b1, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("td_after_3", train_done, 1);
        check("infer_ready", s_ready, 1);
        tick(2);
        check("b2b_lows", lows - bl, 3);
        check("b2b_pulses", pulses - bp, 1);

        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        @(negedge clk);
        check("stop_idle_busy", busy, 0);
        check("td_hold_idle", train_done, 1);
        tick(1);
        go(2);
        bl = lows;
        bp = pulses;
        beat(rnd(), 1'b1, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("td_mid_train", train_done, 0);
        tick(3);
        beat(rnd(), 1'b0, 1'b1);
        s_valid = 1'b0;
        tick(2);
        check("gap_lows", lows - bl, 2);
        check("gap_pulses", pulses - bp, 2);
        check("gap_td", train_done, 1);

        m_ready = 1'b0;
        beat(rnd() | D'(1), 1'b0, 1'b0);
        s_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lat_mv_low", m_valid, 0);
            check("pred_s_ready", s_ready, 0);
        end
        @(negedge clk);
        check("lat3_mv", m_valid, 1);
        check("lat3_label", m_label, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_mv", m_valid, 1);
            check("hold_label", m_label, 1);
            check("hold_s_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        check("post_hs_mv", m_valid, 0);
        check("post_hs_ready", s_ready, 1);
        tick(1);

        s_valid = 1'b1;
        s_hv = rnd();
        stop = 1'b1;
        @(negedge clk);
        check("stop_beat_ready", s_ready, 0);
        tick(1);
        s_valid = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        check("stop_beat_busy", busy, 0);
        check("stop_beat_mv", m_valid, 0);
        tick(1);
        go(0);
        @(negedge clk);
        check("nt0_td", train_done, 1);
        check("nt0_ready", s_ready, 1);
        tick(1);
        bh = hs_cnt;
        m_ready = 1'b1;
        beat(rnd() & ~D'(1), 1'b0, 1'b0);
        s_valid = 1'b0;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_mv();
        n = 0;
        @(negedge clk);
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("pred1_stop_idle", busy, 0);
        check("pred1_stop_hs", hs_cnt - bh, 1);
        tick(1);

        go(NT_RST);
        bl = lows;
        beat(rnd(), 1'b1, 1'b1);
        rst = 1'b1;
        s_valid = 1'b0;
        #1;
        check("rst_mid_op", cls_op, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", s_ready, 0);
        tick(2);
        check("rst_mid_nolow", lows - bl, 0);
        rst = 1'b0;
        tick(1);
        go(0);
        @(negedge clk);
        check("rst_nt0_td", train_done, 1);
        check("rst_nt0_ready", s_ready, 1);
        tick(1);

        bh = hs_cnt;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            beat(rnd() | D'(1), 1'b0, 1'b0);
            s_valid = 1'b0;
            wait_mv();
        end
        check("five_hs", hs_cnt - bh, 5);
`ifdef CLASS_SEQ_STATS_EN
        @(negedge clk);
        check("n_infer_sat", n_infer, SAT < 5 ? SAT : 5);
        check("n_seizure_sat", n_seizure, SAT < 5 ? SAT : 5);
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        go(1);
        @(negedge clk);
        check("n_infer_clr", n_infer, 0);
        check("n_seizure_clr", n_seizure, 0);
`endif
        m_ready = 1'b0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
